// File: rtl/modo_libre_pkg.sv
// modo_libre_pkg: shared states and constants for the multi-note free-play mode
package modo_libre_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, PLAY = 2'd2, HOLD = 2'd3} estado_t;
  localparam logic [7:0] KEY_A = 8'd65;
  localparam logic [7:0] LOWER_OFFSET = 8'd32;
  localparam int NOTA_SILENCIO = 0;
endpackage

// File: rtl/modo_libre_multinota_tecla.sv
// tecla_a_nota: combinational ASCII key to note index decoder (octava output under MODO_LIBRE_OCTAVA_EN)
module tecla_a_nota
  import modo_libre_pkg::*;
#(
  parameter logic [7:0] BASE_KEY = KEY_A,
  parameter int NUM_NOTES = 4,
  parameter int NOTE_W = $clog2(NUM_NOTES + 1)
) (
  input  logic [7:0]        entrada,
  output logic              valid,
  output logic [NOTE_W-1:0] k
`ifdef MODO_LIBRE_OCTAVA_EN
  ,
  output logic              octava
`endif
);
  localparam logic [8:0] LO = {1'b0, BASE_KEY};
  localparam logic [8:0] HI = 9'(int'(BASE_KEY) + NUM_NOTES);
  logic [8:0] code;
  logic v_up;
  assign code = {1'b0, entrada};
  assign v_up = (code >= LO) && (code < HI);
`ifdef MODO_LIBRE_OCTAVA_EN
  // Ranges never overlap because NUM_NOTES is below the case offset
  logic v_lo;
  assign v_lo = (code >= LO + 9'(LOWER_OFFSET)) && (code < HI + 9'(LOWER_OFFSET));
  assign valid = v_up || v_lo;
  assign octava = v_lo;
  assign k = v_lo ? NOTE_W'(entrada - BASE_KEY - LOWER_OFFSET + 8'd1) : NOTE_W'(entrada - BASE_KEY + 8'd1);
`else
  assign valid = v_up;
  assign k = NOTE_W'(entrada - BASE_KEY + 8'd1);
`endif
endmodule

// File: rtl/modo_libre_multinota.sv
// modo_libre_multinota: free-play note FSM with direct note changes, release tail and start strobe
// Optional lowercase octave keys and octava output under MODO_LIBRE_OCTAVA_EN
module modo_libre_multinota
  import modo_libre_pkg::*;
#(
  parameter int NUM_NOTES = 4,
  parameter logic [7:0] BASE_KEY = KEY_A,
  parameter int RELEASE_CYCLES = 0,
  localparam int NOTE_W = $clog2(NUM_NOTES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  input  logic              fin,
  input  logic [7:0]        entrada,
  output logic [NOTE_W-1:0] notaSalida,
  output logic              contar,
  output logic              nota_inicio
`ifdef MODO_LIBRE_OCTAVA_EN
  ,
  output logic              octava
`endif
);
  localparam int CNT_W = RELEASE_CYCLES > 1 ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INI = RELEASE_CYCLES > 0 ? CNT_W'(RELEASE_CYCLES - 1) : '0;
  estado_t state, state_n;
  logic [NOTE_W-1:0] note, note_n, k;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic valid, k_oct, oct, oct_n, pulse_n, sona, diff;
  tecla_a_nota #(.BASE_KEY(BASE_KEY), .NUM_NOTES(NUM_NOTES), .NOTE_W(NOTE_W)) u_tecla (
    .entrada(entrada),
    .valid(valid),
    .k(k)
`ifdef MODO_LIBRE_OCTAVA_EN
    ,
    .octava(k_oct)
`endif
  );
`ifndef MODO_LIBRE_OCTAVA_EN
  assign k_oct = 1'b0;
`endif
  assign diff = (k != note) || (k_oct != oct);
  always_comb begin
    state_n = state;
    note_n = note;
    oct_n = oct;
    cnt_n = cnt;
    pulse_n = 1'b0;
    if (fin) state_n = IDLE;
    else begin
      case (state)
        IDLE: state_n = inicio ? WAIT : IDLE;
        WAIT: if (valid) begin
          state_n = PLAY;
          note_n = k;
          oct_n = k_oct;
          pulse_n = 1'b1;
        end
        PLAY, HOLD: if (valid) begin
          state_n = PLAY;
          note_n = k;
          oct_n = k_oct;
          pulse_n = diff;
        end else if (state == PLAY) begin
          state_n = RELEASE_CYCLES == 0 ? WAIT : HOLD;
          cnt_n = CNT_INI;
        end else if (cnt == '0) state_n = WAIT;
        else cnt_n = cnt - 1'b1;
        default: state_n = IDLE;
      endcase
    end
    sona = (state_n == PLAY) || (state_n == HOLD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      note <= '0;
      oct <= 1'b0;
      cnt <= '0;
      notaSalida <= NOTE_W'(NOTA_SILENCIO);
      contar <= 1'b0;
      nota_inicio <= 1'b0;
`ifdef MODO_LIBRE_OCTAVA_EN
      octava <= 1'b0;
`endif
    end else begin
      state <= state_n;
      note <= note_n;
      oct <= oct_n;
      cnt <= cnt_n;
      notaSalida <= sona ? note_n : NOTE_W'(NOTA_SILENCIO);
      contar <= sona;
      nota_inicio <= pulse_n;
`ifdef MODO_LIBRE_OCTAVA_EN
      octava <= sona && oct_n;
`endif
    end
  end
endmodule
